// File: rtl/mvau_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mvau_ctrl
// Purpose  : Fold sequencer for the SIMD x PE MVU array.
//            Captures the input vector on row fold 0 and replays it from the
//            buffer for the remaining row folds.
// Revision : 1.0
// ============================================================================
module mvau_ctrl #(
    parameter  int MatrixW = 4,
    parameter  int MatrixH = 4,
    parameter  int SIMD    = 2,
    parameter  int PE      = 2,
    localparam int c_SF    = MatrixW / SIMD,
    localparam int c_NF    = MatrixH / PE,
    localparam int c_SFW   = (c_SF > 1) ? $clog2(c_SF) : 1,
    localparam int c_NFW   = (c_NF > 1) ? $clog2(c_NF) : 1,
    localparam int c_WAW   = ((c_SF * c_NF) > 1) ? $clog2(c_SF * c_NF) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    output logic             in_rdy,
    output logic             act_sel,
    output logic             buf_we,
    output logic [c_SFW-1:0] buf_addr,
    output logic [c_WAW-1:0] wgt_addr,
    output logic             mvu_en,
    output logic             acc_clr,
    output logic             acc_last,
    output logic [c_NFW-1:0] nf_idx,
    output logic             out_v,
    input  logic             out_rdy
);

    localparam logic [c_SFW-1:0] c_SF_LAST = c_SFW'(c_SF - 1);
    localparam logic [c_NFW-1:0] c_NF_LAST = c_NFW'(c_NF - 1);
    localparam logic [c_WAW-1:0] c_SF_W    = c_WAW'(c_SF);
    localparam logic             c_MULTI_NF = (c_NF > 1);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_SFW-1:0] r_sf;
    logic [c_SFW-1:0] w_sf_nxt;
    logic [c_NFW-1:0] r_nf;
    logic [c_NFW-1:0] w_nf_nxt;
    logic             r_out_v;
    logic             w_out_v_nxt;

    logic             w_sf_last;
    logic             w_nf_last;
    logic             w_replay;
    logic             w_stall;
    logic             w_issue;

    assign w_sf_last = (r_sf == c_SF_LAST);
    assign w_nf_last = (r_nf == c_NF_LAST);
    assign w_replay  = (r_state == ST_REPLAY);

    // Only the result-producing beat must wait for a free output slot.
    assign w_stall = w_sf_last & r_out_v & ~out_rdy;
    assign w_issue = ~rst & ~w_stall & (w_replay | in_v);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_sf    <= '0;
            r_nf    <= '0;
            r_out_v <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sf    <= w_sf_nxt;
            r_nf    <= w_nf_nxt;
            r_out_v <= w_out_v_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sf_nxt    = r_sf;
        w_nf_nxt    = r_nf;
        if (w_issue) begin
            if (w_sf_last) begin
                w_sf_nxt = '0;
                w_nf_nxt = w_nf_last ? '0 : (r_nf + c_NFW'(1));
                if (!w_replay && (r_nf == '0) && c_MULTI_NF) begin
                    w_state_nxt = ST_REPLAY;
                end else if (w_replay && w_nf_last) begin
                    w_state_nxt = ST_FILL;
                end
            end else begin
                w_sf_nxt = r_sf + c_SFW'(1);
            end
        end
        // Slot stays occupied until taken; a new result may refill it in the same cycle.
        w_out_v_nxt = (w_issue & w_sf_last) | (r_out_v & ~out_rdy);
    end

    always_comb begin
        in_rdy   = ~rst & ~w_replay & ~w_stall;
        mvu_en   = w_issue;
        acc_clr  = w_issue & (r_sf == '0);
        acc_last = w_issue & w_sf_last;
        buf_we   = w_issue & ~w_replay;
        act_sel  = ~rst & w_replay;
        buf_addr = '0;
        wgt_addr = '0;
        nf_idx   = '0;
        if (!rst) begin
            buf_addr = r_sf;
            wgt_addr = (c_WAW'(r_nf) * c_SF_W) + c_WAW'(r_sf);
            nf_idx   = r_nf;
        end
    end

    assign out_v = r_out_v;

endmodule
`default_nettype wire
